// File: rtl/uart_byte_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_bridge
// Description : 8N1 UART front end. Deserialises uart_rx into a show-ahead
//               byte FIFO (rx_data/rx_vld/rx_rdy), and serialises the
//               tx_data/tx_vld/tx_rdy byte stream onto uart_tx.
// Ports       : sys_clk, reset (async, active-high)
//               uart_rx  - serial input from host (asynchronous, idles high)
//               uart_tx  - serial output to host (registered, idles high)
//               rx_data/rx_vld/rx_rdy - received byte stream (FIFO head)
//               tx_data/tx_vld/tx_rdy - byte stream to transmit
//               rx_overflow  - sticky, byte dropped on full FIFO
//               rx_frame_err - one-cycle pulse on a bad stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_bridge #(
    parameter int CLKS_PER_BIT  = 12,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    input  logic       rx_rdy,
    input  logic [7:0] tx_data,
    input  logic       tx_vld,
    output logic       tx_rdy,
    output logic       rx_overflow,
    output logic       rx_frame_err
);

    localparam int c_cw = $clog2(CLKS_PER_BIT);
    localparam int c_aw = $clog2(RX_FIFO_DEPTH);

    localparam logic [c_cw-1:0] c_baud_last    = c_cw'(CLKS_PER_BIT - 1);
    localparam logic [c_cw-1:0] c_baud_last_m1 = c_cw'(CLKS_PER_BIT - 2);
    localparam logic [c_cw-1:0] c_baud_half    = c_cw'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] c_rx_idle  = 2'd0;
    localparam logic [1:0] c_rx_start = 2'd1;
    localparam logic [1:0] c_rx_data  = 2'd2;
    localparam logic [1:0] c_rx_stop  = 2'd3;

    localparam logic [2:0] c_tx_idle  = 3'd0;
    localparam logic [2:0] c_tx_latch = 3'd1;
    localparam logic [2:0] c_tx_start = 3'd2;
    localparam logic [2:0] c_tx_data  = 3'd3;
    localparam logic [2:0] c_tx_stop  = 3'd4;

    // ------------------------------------------------------------------
    // RX line synchroniser (resets to the idle level)
    // ------------------------------------------------------------------
    logic r_rx_meta, r_rx_sync;
    logic w_rxs;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_rxs = r_rx_sync;

    // ------------------------------------------------------------------
    // RX deserialiser
    // ------------------------------------------------------------------
    logic [1:0]      r_rx_state, w_rx_state_n;
    logic [c_cw-1:0] r_rx_baud, w_rx_baud_n;
    logic [2:0]      r_rx_bit, w_rx_bit_n;
    logic [7:0]      r_rx_shift, w_rx_shift_n;
    logic            r_rx_hold, w_rx_hold_n;   // bad stop seen, waiting for line high
    logic            r_frame_err, w_frame_err_n;
    logic            w_rx_push;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_rx_state  <= c_rx_idle;
            r_rx_baud   <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_hold   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_state  <= w_rx_state_n;
            r_rx_baud   <= w_rx_baud_n;
            r_rx_bit    <= w_rx_bit_n;
            r_rx_shift  <= w_rx_shift_n;
            r_rx_hold   <= w_rx_hold_n;
            r_frame_err <= w_frame_err_n;
        end
    end

    always_comb begin
        w_rx_state_n  = r_rx_state;
        w_rx_baud_n   = r_rx_baud + 1'b1;
        w_rx_bit_n    = r_rx_bit;
        w_rx_shift_n  = r_rx_shift;
        w_rx_hold_n   = r_rx_hold;
        w_frame_err_n = 1'b0;
        w_rx_push     = 1'b0;
        case (r_rx_state)
            c_rx_idle: begin
                w_rx_baud_n = '0;
                if (!w_rxs) w_rx_state_n = c_rx_start;
            end
            c_rx_start: begin
                // Mid-bit check rejects glitches shorter than half a bit
                if (r_rx_baud == c_baud_half) begin
                    w_rx_baud_n  = '0;
                    w_rx_bit_n   = '0;
                    w_rx_state_n = w_rxs ? c_rx_idle : c_rx_data;
                end
            end
            c_rx_data: begin
                if (r_rx_baud == c_baud_last) begin
                    w_rx_baud_n  = '0;
                    w_rx_shift_n = {w_rxs, r_rx_shift[7:1]};
                    w_rx_bit_n   = r_rx_bit + 1'b1;
                    if (r_rx_bit == 3'd7) w_rx_state_n = c_rx_stop;
                end
            end
            c_rx_stop: begin
                if (r_rx_hold) begin
                    w_rx_baud_n = '0;
                    if (w_rxs) begin
                        w_rx_hold_n  = 1'b0;
                        w_rx_state_n = c_rx_idle;
                    end
                end else if (r_rx_baud == c_baud_last) begin
                    w_rx_baud_n = '0;
                    if (w_rxs) begin
                        w_rx_push    = 1'b1;
                        w_rx_state_n = c_rx_idle;
                    end else begin
                        w_frame_err_n = 1'b1;
                        w_rx_hold_n   = 1'b1;
                    end
                end
            end
            default: w_rx_state_n = c_rx_idle;
        endcase
    end

    assign rx_frame_err = r_frame_err;

    // ------------------------------------------------------------------
    // RX show-ahead FIFO; pointer MSB is the wrap flag
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [RX_FIFO_DEPTH];
    logic [c_aw:0] r_wr_ptr, r_rd_ptr;
    logic          r_overflow;
    logic          w_empty, w_full, w_pop, w_push_ok;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_pop     = !w_empty && rx_rdy;
    // A pop in the same cycle frees the slot the push needs
    assign w_push_ok = w_rx_push && (!w_full || w_pop);

    always_ff @(posedge sys_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[c_aw-1:0]] <= r_rx_shift;
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_rx_push && !w_push_ok) r_overflow <= 1'b1;
        end
    end

    assign rx_data     = r_mem[r_rd_ptr[c_aw-1:0]];
    assign rx_vld      = !w_empty;
    assign rx_overflow = r_overflow;

    // ------------------------------------------------------------------
    // TX serialiser. The line is registered, so the start bit is already
    // on the wire during LATCH; START therefore lasts one cycle less.
    // STOP also runs one cycle short: its final cycle is spent in IDLE
    // with tx_rdy high so a waiting byte starts with no gap.
    // ------------------------------------------------------------------
    logic [2:0]      r_tx_state, w_tx_state_n;
    logic [c_cw-1:0] r_tx_baud, w_tx_baud_n;
    logic [2:0]      r_tx_bit, w_tx_bit_n;
    logic [7:0]      r_tx_shift, w_tx_shift_n;
    logic            r_tx_line, w_tx_line_n;
    logic            r_tx_rdy, w_tx_rdy_n;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_tx_state <= c_tx_idle;
            r_tx_baud  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_line  <= 1'b1;
            r_tx_rdy   <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_baud  <= w_tx_baud_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_tx_line  <= w_tx_line_n;
            r_tx_rdy   <= w_tx_rdy_n;
        end
    end

    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_baud_n  = r_tx_baud + 1'b1;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_tx_line_n  = r_tx_line;
        w_tx_rdy_n   = r_tx_rdy;
        case (r_tx_state)
            c_tx_idle: begin
                w_tx_baud_n = '0;
                if (tx_vld && r_tx_rdy) begin
                    w_tx_shift_n = tx_data;
                    w_tx_line_n  = 1'b0;
                    w_tx_rdy_n   = 1'b0;
                    w_tx_state_n = c_tx_latch;
                end
            end
            c_tx_latch: begin
                w_tx_baud_n  = '0;
                w_tx_state_n = c_tx_start;
            end
            c_tx_start: begin
                if (r_tx_baud == c_baud_last_m1) begin
                    w_tx_baud_n  = '0;
                    w_tx_bit_n   = '0;
                    w_tx_line_n  = r_tx_shift[0];
                    w_tx_state_n = c_tx_data;
                end
            end
            c_tx_data: begin
                if (r_tx_baud == c_baud_last) begin
                    w_tx_baud_n = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_line_n  = 1'b1;
                        w_tx_state_n = c_tx_stop;
                    end else begin
                        w_tx_bit_n   = r_tx_bit + 1'b1;
                        w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                        w_tx_line_n  = r_tx_shift[1];
                    end
                end
            end
            c_tx_stop: begin
                if (r_tx_baud == c_baud_last_m1) begin
                    w_tx_baud_n  = '0;
                    w_tx_rdy_n   = 1'b1;
                    w_tx_state_n = c_tx_idle;
                end
            end
            default: w_tx_state_n = c_tx_idle;
        endcase
    end

    assign uart_tx = r_tx_line;
    assign tx_rdy  = r_tx_rdy;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_byte_bridge
// Description : Self-checking bench for uart_byte_bridge (CLKS_PER_BIT=4,
//               RX_FIFO_DEPTH=16): table of RX frames plus hand-written
//               overflow, push/pop, TX and reset-mid-frame sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_byte_bridge;

    localparam int C = 4;
    localparam int D = 16;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rx_rdy  = 1'b0;
    logic       tx_vld  = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       uart_tx, rx_vld, tx_rdy, rx_overflow, rx_frame_err;
    logic [7:0] rx_data;

    uart_byte_bridge #(.CLKS_PER_BIT(C), .RX_FIFO_DEPTH(D)) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .uart_tx     (uart_tx),
        .rx_data     (rx_data),
        .rx_vld      (rx_vld),
        .rx_rdy      (rx_rdy),
        .tx_data     (tx_data),
        .tx_vld      (tx_vld),
        .tx_rdy      (tx_rdy),
        .rx_overflow (rx_overflow),
        .rx_frame_err(rx_frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor: counts only grow; tests work on differences
    logic [7:0] rx_q[$];
    int vld_cycles = 0;
    int ferr_cnt   = 0;

    always @(negedge sys_clk) begin
        if (rx_vld) vld_cycles++;
        if (rx_vld && rx_rdy) rx_q.push_back(rx_data);
        if (rx_frame_err) ferr_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Entered just after a rising edge; leaves the line idle for one bit
    task automatic send_frame(input logic [7:0] d, input logic stop);
        uart_rx = 1'b0;
        wait_cyc(C);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            wait_cyc(C);
        end
        uart_rx = stop;
        wait_cyc(C);
        uart_rx = 1'b1;
        wait_cyc(C);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);
    endtask

    // Checks {uart_tx, tx_rdy} every cycle for one or two back-to-back bytes
    task automatic tx_frames(input logic [7:0] d0, input logic [7:0] d1, input int nbytes);
        logic [7:0] d;
        int kk, j;
        logic exp_tx, exp_rdy;
        check("tx_rdy_before", {31'd0, tx_rdy}, 32'd1);
        tx_data = d0;
        tx_vld  = 1'b1;
        for (int k = 1; k <= 10*C*nbytes; k++) begin
            wait_cyc(1);
            tx_data = d1;
            tx_vld  = (k <= 10*C*(nbytes-1));
            @(negedge sys_clk);
            d  = (k <= 10*C) ? d0 : d1;
            kk = k - ((k-1)/(10*C))*(10*C);
            j  = (kk-1)/C;
            exp_tx  = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : d[j-1];
            exp_rdy = (kk == 10*C);
            check("tx_line_rdy", {30'd0, uart_tx, tx_rdy}, {30'd0, exp_tx, exp_rdy});
        end
        tx_vld = 1'b0;
        wait_cyc(1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_push;
        int         exp_ferr;
    } rx_vec_t;

    rx_vec_t vecs[7];
    int q0, v0, f0;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
        vecs[1] = '{8'h3C, 1'b0, 8'h00, 0, 1};
        vecs[2] = '{8'h3C, 1'b1, 8'h3C, 1, 0};
        vecs[3] = '{8'h00, 1'b1, 8'h00, 1, 0};
        vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
        vecs[5] = '{8'h81, 1'b1, 8'h81, 1, 0};
        vecs[6] = '{8'h55, 1'b0, 8'h00, 0, 1};

        // Reset values
        wait_cyc(2);
        check("rst_uart_tx",      {31'd0, uart_tx},      32'd1);
        check("rst_tx_rdy",       {31'd0, tx_rdy},       32'd1);
        check("rst_rx_vld",       {31'd0, rx_vld},       32'd0);
        check("rst_rx_overflow",  {31'd0, rx_overflow},  32'd0);
        check("rst_rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
        reset = 1'b0;
        wait_cyc(3);

        // One-cycle glitch on the line must not start a byte
        rx_rdy = 1'b1;
        q0 = rx_q.size();
        uart_rx = 1'b0;
        wait_cyc(1);
        uart_rx = 1'b1;
        wait_cyc(3*C);
        check("glitch_no_push", rx_q.size() - q0, 32'd0);
        check("glitch_rx_vld",  {31'd0, rx_vld},  32'd0);

        // Table of RX frames, consumer always ready
        for (int i = 0; i < 7; i++) begin
            q0 = rx_q.size(); v0 = vld_cycles; f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop);
            wait_cyc(C);
            check("rx_push_count",  rx_q.size() - q0,  vecs[i].exp_push);
            check("rx_vld_cycles",  vld_cycles - v0,   vecs[i].exp_push);
            check("rx_frame_err_n", ferr_cnt - f0,     vecs[i].exp_ferr);
            if (vecs[i].exp_push == 1 && rx_q.size() > q0)
                check("rx_data", {24'd0, rx_q[q0]}, {24'd0, vecs[i].exp_data});
        end
        check("rx_no_overflow", {31'd0, rx_overflow}, 32'd0);

        // Overflow: 17 bytes into a 16-entry FIFO with no consumer
        rx_rdy = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1);
            if (i == 15) check("ovf_not_yet", {31'd0, rx_overflow}, 32'd0);
        end
        check("ovf_set", {31'd0, rx_overflow}, 32'd1);
        q0 = rx_q.size();
        rx_rdy = 1'b1;
        wait_cyc(24);
        rx_rdy = 1'b0;
        check("ovf_drain_count", rx_q.size() - q0, 32'd16);
        for (int i = 0; i < 16; i++)
            if (rx_q.size() > q0 + i)
                check("ovf_drain_data", {24'd0, rx_q[q0+i]}, i);
        check("ovf_empty", {31'd0, rx_vld}, 32'd0);

        // Simultaneous push and pop on a full FIFO
        do_reset();
        check("rst_clears_ovf", {31'd0, rx_overflow}, 32'd0);
        for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 1'b1);
        q0 = rx_q.size();
        fork
            send_frame(8'h30, 1'b1);
            begin
                wait_cyc(40);      // cycle of the stop-bit sample
                rx_rdy = 1'b1;
                wait_cyc(1);
                rx_rdy = 1'b0;
            end
        join
        check("pp_no_overflow", {31'd0, rx_overflow}, 32'd0);
        rx_rdy = 1'b1;
        wait_cyc(24);
        rx_rdy = 1'b0;
        check("pp_total_count", rx_q.size() - q0, 32'd17);
        for (int i = 0; i < 17; i++)
            if (rx_q.size() > q0 + i)
                check("pp_data", {24'd0, rx_q[q0+i]}, 32'h20 + i);

        // TX: 0x5A then 0xFF back-to-back
        tx_frames(8'h5A, 8'hFF, 2);

        // Reset in the middle of a TX and an RX frame
        send_frame(8'h11, 1'b1);
        check("pre_rst_rx_vld", {31'd0, rx_vld}, 32'd1);
        fork
            send_frame(8'h96, 1'b1);
            begin
                wait_cyc(8);
                tx_data = 8'hC3;
                tx_vld  = 1'b1;
                wait_cyc(1);
                tx_vld  = 1'b0;
                wait_cyc(17);      // TX data bit 3 (a 0), RX data bit 5
                reset = 1'b1;
                #1;
                check("midrst_uart_tx", {31'd0, uart_tx}, 32'd1);
                check("midrst_tx_rdy",  {31'd0, tx_rdy},  32'd1);
                check("midrst_rx_vld",  {31'd0, rx_vld},  32'd0);
            end
        join
        reset = 1'b0;
        wait_cyc(4);
        check("post_rst_rx_vld", {31'd0, rx_vld}, 32'd0);
        q0 = rx_q.size();
        rx_rdy = 1'b1;
        send_frame(8'h81, 1'b1);
        wait_cyc(C);
        check("rt_rx_count", rx_q.size() - q0, 32'd1);
        if (rx_q.size() > q0) check("rt_rx_data", {24'd0, rx_q[q0]}, 32'h81);
        tx_frames(8'h81, 8'h81, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_byte_bridge.md
# uart_byte_bridge

Byte-serial UART front end for the uCaspian top level. It deserializes the host UART line into a buffered byte stream that drives the packet interface's RX port (read_data/read_vld/read_rdy). It also serializes the packet interface's TX byte stream (write_data/write_vld/write_rdy) onto the UART line. Frame format is fixed 8N1, LSB first, and the baud rate is set by a compile-time divider.

## Interface
- CLKS_PER_BIT, 12: sys_clk cycles per UART bit; must be at least 4.
- RX_FIFO_DEPTH, 16: RX byte FIFO entries; must be a power of 2, at least 2.
- sys_clk  in  1  single clock; everything in this block is synchronous to it.
- reset  in  1  asynchronous, active-high.
- uart_rx  in  1  serial line from host; asynchronous to sys_clk; idles high.
- uart_tx  out  1  serial line to host; registered; reset value 1.
- rx_data  out  8  head of RX FIFO; undefined while rx_vld=0.
- rx_vld  out  1  RX FIFO not empty; reset value 0.
- rx_rdy  in  1  consumer accepts rx_data.
- tx_data  in  8  byte to transmit.
- tx_vld  in  1  tx_data valid.
- tx_rdy  out  1  serializer idle; registered; reset value 1.
- rx_overflow  out  1  sticky: a received byte was dropped because the FIFO was full; cleared only by reset; reset value 0.
- rx_frame_err  out  1  one-cycle pulse on a bad stop bit; reset value 0.

## Operation
- RX synchronizer: a 2-flop synchronizer on uart_rx, reset to 1. All RX logic uses the synchronized value, called rxs.
- RX FSM has four states: IDLE, START, DATA, STOP. A bit counter counts 0..7 and a baud counter counts 0..CLKS_PER_BIT-1.
  - IDLE -> START when rxs=0.
  - START: wait CLKS_PER_BIT/2 cycles, then sample rxs.
    - Sample =1: false start; return to IDLE with no other effect.
    - Sample =0: go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles; the 8 samples fill the shift register LSB first; after bit 7, go to STOP.
  - STOP: sample CLKS_PER_BIT cycles after bit 7.
    - rxs=1: push the byte to the FIFO, then go to IDLE.
    - rxs=0: pulse rx_frame_err, drop the byte, stay in STOP until rxs=1, then go to IDLE.
- RX FIFO is show-ahead.
  - Pop when rx_vld && rx_rdy.
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle (full with simultaneous pop: occupancy stays full).
  - A push while full with no pop is dropped and sets rx_overflow.
  - Pointers are log2(RX_FIFO_DEPTH)+1 bits wide, with the extra bit as wrap flag. Full and empty are derived from the pointers, so the FIFO holds all RX_FIFO_DEPTH entries.
- TX FSM has five states: IDLE, START, DATA, STOP, plus a one-cycle latch step.
  - Byte accepted on tx_vld && tx_rdy; tx_data is latched in that cycle and tx_rdy drops the next cycle.
  - Line sequence: start bit 0, then data bits 0..7, then stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
  - tx_rdy rises in the last cycle of the stop bit, so a back-to-back byte's start bit follows with no idle gap.
- Reset mid-operation: all state is cleared asynchronously. The FIFO empties, uart_tx=1, tx_rdy=1, and any partial RX or TX frame is discarded.

## Timing
- Cycle t is the first cycle with rxs=0 (2 cycles after the uart_rx edge).
  - Start sample at t+CLKS_PER_BIT/2.
  - Data bit i sampled at t+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT.
  - Stop bit sampled at t+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
- rx_vld rises the cycle after the stop sample when the FIFO was empty.
- rx_data is stable while rx_vld=1 and rx_rdy=0.
- Pop takes effect at the clock edge; the next entry appears the following cycle with no bubble.
- TX: uart_tx falls the cycle after acceptance.
  - tx_rdy is low for 10*CLKS_PER_BIT-1 cycles per byte.
  - Sustained throughput is one byte per 10*CLKS_PER_BIT cycles.
- Tolerance: ±4% clock mismatch for CLKS_PER_BIT≥8.

## Test plan
All scenarios use CLKS_PER_BIT=4 and RX_FIFO_DEPTH=16.
- Single byte: drive 0xA5 frame on uart_rx with rx_rdy=1 -> rx_vld high exactly 1 cycle carrying 0xA5; rx_overflow=0; rx_frame_err=0.
- Overflow: rx_rdy=0, send bytes 0x00..0x10 -> rx_overflow set on the 17th byte; draining yields 0x00..0x0F in order, then rx_vld=0.
- Glitch and framing:
  - uart_rx low for 1 cycle -> no push, RX FSM back in IDLE.
  - 0x3C with stop bit 0 -> one rx_frame_err pulse, no push.
  - Then a clean 0x3C -> 0x3C received.
- TX: tx_data=0x5A pulsed with tx_vld -> uart_tx reads 0,0,1,0,1,1,0,1,0,1, each level held 4 cycles; tx_rdy low 39 cycles.
  - A second byte 0xFF held on tx_vld starts immediately after the first stop bit with no gap.
- Simultaneous push/pop: FIFO full, rx_rdy=1 on the cycle a new byte's stop sample completes -> byte accepted, no overflow, count stays 16.
- Reset mid-frame: assert reset during TX data bit 3 and RX data bit 5 -> uart_tx=1 and tx_rdy=1 immediately, rx_vld=0.
  - After release, a fresh 0x81 round-trips correctly on both RX and TX.
